ofdm_cp_insert: RTL and testbench
=================================

Name: ofdm_cp_insert

Overview:
- Cyclic-prefix inserter directly downstream of the inverse R4 FFT in the OFDM transmit chain.
- Buffers each NFFT-sample IFFT output symbol in a ping-pong RAM.
- Emits the last CP_LEN samples (cyclic prefix) followed by the full symbol, giving NFFT+CP_LEN samples per symbol.
- Drives the FFT's flag_ready_recive through in_ready, so the FFT stalls whenever both banks are full.

Parameters:
- SIZE_BUFFER, 8, log2 of NFFT; NFFT = 2**SIZE_BUFFER.
- DATA_SIZE, 22, I/Q sample width; matches FFT output width 16+SIZE_BUFFER-2.
- CP_LEN, 64, cyclic prefix length in samples; legal range 1..NFFT/2. Any other value is an elaboration error via a generate-time $error.

Ports:
- clk, input, 1, single clock for all logic.
- reset, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, input sample valid; driven from FFT complete.
- data_in_i, input, DATA_SIZE, input I sample, two's complement.
- data_in_q, input, DATA_SIZE, input Q sample, two's complement.
- in_ready, output, 1, write bank free; drives FFT flag_ready_recive.
- out_valid, output, 1, output sample valid.
- out_ready, input, 1, downstream accepts the output sample.
- data_out_i, output, DATA_SIZE, output I sample.
- data_out_q, output, DATA_SIZE, output Q sample.
- sym_start, output, 1, high with the first CP sample of each symbol.
- sym_last, output, 1, high with the last body sample of each symbol.

Behaviour:
- Reset (reset=0, async): both banks marked empty; write bank=0; wr_cnt=0; read FSM=IDLE; in_ready=0 while reset is asserted and 1 in the first cycle after release. out_valid, sym_start, sym_last and data_out_* are all 0. Reset mid-symbol discards all buffered data; no partial symbol is ever output.
- Write side:
  - A sample is accepted when in_valid && in_ready and written to wr_bank[wr_cnt]; wr_cnt then increments.
  - On wr_cnt=NFFT-1 accept: the bank is marked full, wr_cnt wraps to 0 and wr_bank toggles.
  - in_ready = !full[wr_bank]. If in_valid drops mid-symbol, wr_cnt holds; there is no timeout.
- Read FSM, states IDLE, CP, BODY:
  - IDLE -> CP when full[rd_bank]; rd_addr = NFFT-CP_LEN.
  - CP: on each output accept (out_valid && out_ready), rd_addr++. After CP_LEN accepts, rd_addr wraps to 0 -> BODY.
  - BODY: NFFT accepts. On the last accept, full[rd_bank] is cleared and rd_bank toggles. If the other bank is full, go to CP in the same cycle (no bubble); otherwise go to IDLE.
- Output is registered with one-cycle RAM read latency. Prefetch keeps out_valid continuous while out_ready=1.
- While out_valid && !out_ready, data_out_*, sym_start and sym_last hold stable and no address advances.
- Latency: out_valid rises exactly 2 cycles after acceptance of the last input sample of a symbol when the read side is IDLE.
- Throughput: with out_ready=1, one output per cycle; symbol period NFFT+CP_LEN cycles. With in_valid continuous, in_ready deasserts periodically because input rate exceeds output rate.
- Simultaneous events:
  - A write that fills a bank in the same cycle the read side frees the other bank: both take effect, and in_ready reflects the new state the next cycle.
  - A bank freed in cycle n may be rewritten from cycle n+1.
- Sample data passes through unmodified: no scaling, no sign manipulation.

Optional Feature:
- Macro OFDM_CP_OVF_EN.
- When defined: adds output port ovf_err (1 bit), a sticky flag set when in_valid=1 && in_ready=0 and cleared only by reset.
- When undefined: the port and its logic are absent; in_valid while in_ready=0 is silently ignored (upstream is required to stall).

Test Plan:
- SIZE_BUFFER=4, CP_LEN=4, input samples 0..15 continuous, out_ready=1 -> out_valid 2 cycles after sample 15. Output sequence 12,13,14,15,0..15 (20 samples). sym_start on the first sample, sym_last on the 20th.
- Default parameters, 3 back-to-back symbols with ramp data and out_ready=1 -> 3×320 contiguous outputs, no gaps. Each symbol = samples 192..255 then 0..255. in_ready low whenever both banks are full.
- out_ready toggled pseudo-randomly 50% -> output sequence identical to the stall-free case. data_out_* stable during every stall cycle.
- reset pulsed low at sample 100 of a symbol, mid-output of the previous symbol -> outputs 0 immediately. After release, in_ready=1 and the next 256 inputs form a clean first symbol.
- Both banks full, out_ready=0, in_valid=1 -> in_ready=0, buffer contents unchanged. With OFDM_CP_OVF_EN defined, ovf_err=1 and it stays set until reset.
- in_valid gapped (1 cycle on, 3 off) -> output content correct. First output occurs 2 cycles after the 256th accepted sample.

Source files
------------

// File: rtl/ofdm_cp_insert.sv
// rtl/ofdm_cp_insert.sv - OFDM cyclic-prefix inserter with ping-pong symbol buffer
//
// Buffers NFFT-sample IFFT symbols in two RAM banks. For each full bank it emits
// the last CP_LEN samples (cyclic prefix) followed by the whole symbol.
//
// Parameters:
//   SIZE_BUFFER  log2 of NFFT
//   DATA_SIZE    I/Q sample width
//   CP_LEN       cyclic prefix length, 1..NFFT/2
//
// Ports:
//   clk, reset (async, active low)
//   in_valid, data_in_i, data_in_q, in_ready      : symbol input, in_ready = write bank free
//   out_valid, out_ready, data_out_i, data_out_q  : sample output
//   sym_start / sym_last                          : first CP sample / last body sample
//   ovf_err (only with OFDM_CP_OVF_EN)            : sticky, in_valid seen while in_ready low
//
// Optional feature macro: OFDM_CP_OVF_EN
module ofdm_cp_insert #(
    parameter int SIZE_BUFFER = 8,
    parameter int DATA_SIZE   = 22,
    parameter int CP_LEN      = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] data_in_i,
    input  logic [DATA_SIZE-1:0] data_in_q,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] data_out_i,
    output logic [DATA_SIZE-1:0] data_out_q,
    output logic                 sym_start,
    output logic                 sym_last
`ifdef OFDM_CP_OVF_EN
    ,
    output logic                 ovf_err
`endif
);

    localparam int NFFT = 1 << SIZE_BUFFER;
    localparam logic [SIZE_BUFFER-1:0] CP_START  = SIZE_BUFFER'(NFFT - CP_LEN);
    localparam logic [SIZE_BUFFER-1:0] ADDR_LAST = {SIZE_BUFFER{1'b1}};

    if (CP_LEN < 1 || CP_LEN > NFFT / 2) begin : g_bad_cp_len
        $error("ofdm_cp_insert: CP_LEN must be in 1..NFFT/2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CP,
        ST_BODY
    } rd_state_t;

    // Ping-pong storage: address MSB selects the bank.
    logic [DATA_SIZE-1:0] mem_i [0:2*NFFT-1];
    logic [DATA_SIZE-1:0] mem_q [0:2*NFFT-1];

    logic [1:0]             full;
    logic [1:0]             full_nxt;
    logic                   wr_bank;
    logic                   wr_bank_nxt;
    logic [SIZE_BUFFER-1:0] wr_cnt;
    logic                   rd_bank;
    logic [SIZE_BUFFER-1:0] rd_addr;
    rd_state_t              state;

    logic wr_en;
    logic wr_fill;
    logic ld;
    logic rd_done;

    assign wr_en   = in_valid && in_ready;
    assign wr_fill = wr_en && (wr_cnt == ADDR_LAST);

    // The output register doubles as the RAM read register: a new word is loaded
    // whenever it is empty or being consumed, so the address runs one ahead of the
    // accepted sample and the stream stays gap-free with out_ready held high.
    assign ld      = (state != ST_IDLE) && (!out_valid || out_ready);
    assign rd_done = ld && (state == ST_BODY) && (rd_addr == ADDR_LAST);

    // Fill and free always hit different banks: a bank being read is full and so
    // can never be the write bank.
    always_comb begin
        full_nxt = full;
        if (wr_fill) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
        wr_bank_nxt = wr_bank ^ wr_fill;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_i[{wr_bank, wr_cnt}] <= data_in_i;
            mem_q[{wr_bank, wr_cnt}] <= data_in_q;
        end
    end

    // Write side and bank status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            in_ready <= 1'b0;
        end else begin
            full     <= full_nxt;
            wr_bank  <= wr_bank_nxt;
            in_ready <= !full_nxt[wr_bank_nxt];
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Read FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rd_bank    <= 1'b0;
            rd_addr    <= '0;
            out_valid  <= 1'b0;
            data_out_i <= '0;
            data_out_q <= '0;
            sym_start  <= 1'b0;
            sym_last   <= 1'b0;
        end else begin
            if (!out_valid || out_ready) begin
                out_valid <= (state != ST_IDLE);
                if (state != ST_IDLE) begin
                    data_out_i <= mem_i[{rd_bank, rd_addr}];
                    data_out_q <= mem_q[{rd_bank, rd_addr}];
                    sym_start  <= (state == ST_CP) && (rd_addr == CP_START);
                    sym_last   <= (state == ST_BODY) && (rd_addr == ADDR_LAST);
                end else begin
                    sym_start  <= 1'b0;
                    sym_last   <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (full[rd_bank]) begin
                        state   <= ST_CP;
                        rd_addr <= CP_START;
                    end
                end
                ST_CP: begin
                    if (ld) begin
                        if (rd_addr == ADDR_LAST) begin
                            rd_addr <= '0;
                            state   <= ST_BODY;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                ST_BODY: begin
                    if (ld) begin
                        if (rd_addr == ADDR_LAST) begin
                            rd_bank <= ~rd_bank;
                            // Chain straight into the next prefix when the other
                            // bank is (or just became) full, so no bubble appears.
                            if (full_nxt[~rd_bank]) begin
                                state   <= ST_CP;
                                rd_addr <= CP_START;
                            end else begin
                                state   <= ST_IDLE;
                                rd_addr <= '0;
                            end
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef OFDM_CP_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// tb/tb_ofdm_cp_insert.sv - directed self-checking bench for ofdm_cp_insert
module tb_ofdm_cp_insert;

    localparam int SB   = 8;
    localparam int DS   = 22;
    localparam int CPL  = 64;
    localparam int NFFT = 256;
    localparam int SYM  = NFFT + CPL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DS-1:0] data_in_i = '0;
    logic [DS-1:0] data_in_q = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DS-1:0] data_out_i;
    logic [DS-1:0] data_out_q;
    logic          sym_start;
    logic          sym_last;
`ifdef OFDM_CP_OVF_EN
    logic          ovf_err;
`endif

    ofdm_cp_insert #(
        .SIZE_BUFFER(SB),
        .DATA_SIZE  (DS),
        .CP_LEN     (CPL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in_i (data_in_i),
        .data_in_q (data_in_q),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out_i(data_out_i),
        .data_out_q(data_out_q),
        .sym_start (sym_start),
        .sym_last  (sym_last)
`ifdef OFDM_CP_OVF_EN
        ,
        .ovf_err   (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rdy_mode = 0;
    int          stall_waits = 0;
    logic [45:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [DS-1:0] smp_i(input int base, input int n);
        return DS'(base + n);
    endfunction

    function automatic logic [DS-1:0] smp_q(input int base, input int n);
        return ~DS'(base + n);
    endfunction

    task automatic push_symbol(input int base);
        for (int k = 0; k < SYM; k++) begin
            int n;
            n = (k < CPL) ? (NFFT - CPL + k) : (k - CPL);
            exp_q.push_back({k == 0, k == SYM - 1, smp_i(base, n), smp_q(base, n)});
        end
    endtask

    // Sends one symbol; stop_at >= 0 aborts after that many accepted samples.
    task automatic send_symbol(input int base, input bit gapped, input int stop_at, input bit chk_lat);
        int limit;
        limit = (stop_at < 0) ? NFFT : stop_at;
        for (int n = 0; n < limit; n++) begin
            int wait_cnt;
            in_valid  = 1'b1;
            data_in_i = smp_i(base, n);
            data_in_q = smp_q(base, n);
            wait_cnt  = 0;
            @(negedge clk);
            while (!in_ready && wait_cnt < 3000) begin
                stall_waits++;
                wait_cnt++;
                @(negedge clk);
            end
            if (!in_ready) begin
                check_eq("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (gapped && n != limit - 1) begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (stop_at < 0) begin
            push_symbol(base);
        end
        if (chk_lat) begin
            @(posedge clk);
            #1;
            check_eq("lat_cycle1_valid", out_valid, 0);
            @(posedge clk);
            #1;
            check_eq("lat_cycle2_valid", out_valid, 1);
            check_eq("lat_first_i", data_out_i, smp_i(base, NFFT - CPL));
            check_eq("lat_sym_start", sym_start, 1);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check_eq("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check_eq("idle_after_drain", out_valid, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output scoreboard and stall-stability monitor.
    initial begin
        logic        prev_stall;
        logic [45:0] prev_word;
        logic [45:0] w;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_hold", {out_valid, sym_start, sym_last, data_out_i, data_out_q},
                             {1'b1, prev_word});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_output", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check_eq("out_word", {sym_start, sym_last, data_out_i, data_out_q}, w);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = {sym_start, sym_last, data_out_i, data_out_q};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_flags", {sym_start, sym_last}, 0);
        check_eq("rst_data", {data_out_i, data_out_q}, 0);
`ifdef OFDM_CP_OVF_EN
        check_eq("rst_ovf", ovf_err, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);

        // Single symbol, continuous, latency check
        rdy_mode = 0;
        send_symbol(22'h001000, 1'b0, -1, 1'b1);
        drain();

        // Three back-to-back symbols, no output gaps, input back-pressure
        stall_waits = 0;
        fork
            begin
                send_symbol(22'h002000, 1'b0, -1, 1'b0);
                send_symbol(22'h3FFF80, 1'b0, -1, 1'b0);
                send_symbol(22'h1FFFC0, 1'b0, -1, 1'b0);
            end
            begin
                int c;
                int gaps;
                c = 0;
                do begin
                    @(negedge clk);
                    c++;
                end while (!out_valid && c < 2000);
                check_eq("burst_start", out_valid, 1);
                gaps = 0;
                repeat (3 * SYM - 1) begin
                    @(negedge clk);
                    if (!out_valid) gaps++;
                end
                check_eq("burst_gaps", gaps, 0);
            end
        join
        check_eq("in_ready_backpressure", stall_waits > 0, 1);
        drain();

        // Random out_ready
        rdy_mode = 1;
        send_symbol(22'h004000, 1'b0, -1, 1'b0);
        send_symbol(22'h005000, 1'b0, -1, 1'b0);
        drain();
        rdy_mode = 0;

        // Both banks full with output stalled, extra input ignored
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_symbol(22'h006000, 1'b0, -1, 1'b0);
        send_symbol(22'h007000, 1'b0, -1, 1'b0);
        in_valid  = 1'b1;
        data_in_i = 22'h3FFFFF;
        data_in_q = 22'h155555;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_out_held_i", data_out_i, smp_i(22'h006000, NFFT - CPL));
`ifdef OFDM_CP_OVF_EN
        check_eq("ovf_set", ovf_err, 1);
`endif
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();
`ifdef OFDM_CP_OVF_EN
        check_eq("ovf_sticky", ovf_err, 1);
`endif

        // Reset mid-symbol while the previous symbol is being output
        send_symbol(22'h008000, 1'b0, -1, 1'b0);
        send_symbol(22'h009000, 1'b0, 100, 1'b0);
        check_eq("pre_reset_busy", out_valid, 1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_data", {data_out_i, data_out_q, sym_start, sym_last}, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
`ifdef OFDM_CP_OVF_EN
        check_eq("mid_rst_ovf", ovf_err, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rerst_in_ready", in_ready, 1);
        check_eq("rerst_out_valid", out_valid, 0);

        // Clean symbol after reset, gapped input, latency check
        send_symbol(22'h00A000, 1'b1, -1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
